// File: rtl/datapath_unit.sv
// Execution datapath driven by the CPU control unit: program counter,
// instruction register, register file, ALU, write-back mux and a
// synchronous data memory. Every state change is an explicit command
// sampled on the rising edge of CLK; the block does no sequencing itself.
module datapath_unit #(
    parameter int DATA_W  = 16,
    parameter int PC_W    = 8,
    parameter int DMEM_AW = 8,
    parameter int RF_AW   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               PC_CLR,
    input  logic               PC_LD,
    input  logic               PC_IC,
    input  logic               IR_LD,
    input  logic [DATA_W-1:0]  I_DATA,
    output logic [PC_W-1:0]    I_ADDR,
    output logic [DATA_W-1:0]  IR,
    input  logic [DMEM_AW-1:0] D_ADDR,
    input  logic               D_WR,
    input  logic               RF_S,
    input  logic               RF_W_EN,
    input  logic [RF_AW-1:0]   RF_W_ADDR,
    input  logic [RF_AW-1:0]   RF_RA_ADDR,
    input  logic [RF_AW-1:0]   RF_RB_ADDR,
    input  logic [2:0]         ALU_S,
    output logic [DATA_W-1:0]  ALU_OUT,
    output logic               ALU_Z
);

    localparam int RF_N   = 1 << RF_AW;
    localparam int DMEM_N = 1 << DMEM_AW;

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] mrd_q;
    logic [DATA_W-1:0] rf_q  [RF_N];
    logic [DATA_W-1:0] mem_q [DMEM_N];

    logic [DATA_W-1:0] rf_a;
    logic [DATA_W-1:0] rf_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] wb_data;

    // Asynchronous register reads; a write becomes visible only after the edge.
    assign rf_a = rf_q[RF_RA_ADDR];
    assign rf_b = rf_q[RF_RB_ADDR];

    // PC next state: clear beats load beats increment; load uses the IR held before the edge.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
        pc_d = pc_q;
        if (PC_CLR) begin
            pc_d = '0;
        end else if (PC_LD) begin
            pc_d = ir_q[PC_W-1:0];
        end else if (PC_IC) begin
            pc_d = pc_q + PC_W'(1);
        end
    end

    // IR next state, independent of the PC commands.
    always_comb begin
        ir_d = IR_LD ? I_DATA : ir_q;
    end

    // ALU: modular arithmetic, carries and borrows discarded.
    always_comb begin
        alu_res = '0;
        case (ALU_S)
            3'd0:    alu_res = '0;
            3'd1:    alu_res = rf_a + rf_b;
            3'd2:    alu_res = rf_a - rf_b;
            3'd3:    alu_res = rf_a;
            3'd4:    alu_res = rf_a ^ rf_b;
            3'd5:    alu_res = rf_a | rf_b;
            3'd6:    alu_res = rf_a & rf_b;
            3'd7:    alu_res = rf_a + DATA_W'(1);
            default: alu_res = '0;
        endcase
    end

    // Write-back source: memory read register or ALU result.
    assign wb_data = RF_S ? mrd_q : alu_res;

    // PC, IR and memory read register; reset discards any command in flight.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            pc_q  <= '0;
            ir_q  <= '0;
            mrd_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            mrd_q <= mem_q[D_ADDR];
        end
    end

    // Register file: every register cleared on reset, r0 is an ordinary register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < RF_N; i++) begin
                rf_q[i] <= '0;
            end
        end else if (RF_W_EN) begin
            rf_q[RF_W_ADDR] <= wb_data;
        end
    end

    // Data memory write of the pre-edge A operand; the read above returns the old word.
    always_ff @(posedge CLK) begin
        // NOTE: the data memory has no reset so it maps onto RAM; contents survive RST.
        if (!RST && D_WR) begin
            mem_q[D_ADDR] <= rf_a;
        end
    end

    assign I_ADDR  = pc_q;
    assign IR      = ir_q;
    assign ALU_OUT = alu_res;
    assign ALU_Z   = (alu_res == '0);

endmodule

// File: tb/tb_datapath_unit.sv
// Self-checking bench for datapath_unit: directed scenarios plus randomized
// commands compared every cycle against an array-based behavioural model.
module tb_datapath_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, pc_clr, pc_ld, pc_ic, ir_ld;
    logic [15:0] i_data;
    logic [7:0]  i_addr;
    logic [15:0] ir;
    logic [7:0]  d_addr;
    logic        d_wr, rf_s, rf_w_en;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
    logic [2:0]  alu_s;
    logic [15:0] alu_out;
    logic        alu_z;

    datapath_unit dut (
        .CLK        (clk),
        .RST        (rst),
        .PC_CLR     (pc_clr),
        .PC_LD      (pc_ld),
        .PC_IC      (pc_ic),
        .IR_LD      (ir_ld),
        .I_DATA     (i_data),
        .I_ADDR     (i_addr),
        .IR         (ir),
        .D_ADDR     (d_addr),
        .D_WR       (d_wr),
        .RF_S       (rf_s),
        .RF_W_EN    (rf_w_en),
        .RF_W_ADDR  (rf_w_addr),
        .RF_RA_ADDR (rf_ra_addr),
        .RF_RB_ADDR (rf_rb_addr),
        .ALU_S      (alu_s),
        .ALU_OUT    (alu_out),
        .ALU_Z      (alu_z)
    );

    // Behavioural model state.
    logic [15:0] m_reg [16];
    logic [15:0] m_mem [256];
    logic [15:0] m_mrd;
    logic [15:0] m_ir;
    logic [7:0]  m_pc;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] alu_ref(input logic [2:0] s, input logic [15:0] a, input logic [15:0] b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned r = 0;
        case (s)
            3'd0: r = 0;
            3'd1: r = x + y;
            3'd2: r = x - y;
            3'd3: r = x;
            3'd4: r = x ^ y;
            3'd5: r = x | y;
            3'd6: r = x & y;
            3'd7: r = x + 1;
            default: r = 0;
        endcase
        return 16'(r % 65536);
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge(input logic [15:0] alu_val);
        logic [15:0] a, wb, new_mrd;
        if (rst) begin
            m_pc  = 8'h00;
            m_ir  = 16'h0000;
            m_mrd = 16'h0000;
            for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
            return;
        end
        a       = m_reg[rf_ra_addr];
        wb      = rf_s ? m_mrd : alu_val;
        new_mrd = m_mem[d_addr];
        if (d_wr)    m_mem[d_addr] = a;
        if (rf_w_en) m_reg[rf_w_addr] = wb;
        m_mrd = new_mrd;
        if (pc_clr)     m_pc = 8'h00;
        else if (pc_ld) m_pc = m_ir[7:0];
        else if (pc_ic) m_pc = 8'((int'(m_pc) + 1) % 256);
        if (ir_ld) m_ir = i_data;
    endtask

    // One cycle: check visible outputs against the model, clock, update model.
    task automatic cyc();
        logic [15:0] e;
        #1;
        e = alu_ref(alu_s, m_reg[rf_ra_addr], m_reg[rf_rb_addr]);
        check("alu_out", alu_out, e);
        check("alu_z", {15'b0, alu_z}, {15'b0, (e == 16'h0000)});
        check("i_addr", {8'h00, i_addr}, {8'h00, m_pc});
        check("ir", ir, m_ir);
        @(posedge clk);
        model_edge(e);
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; pc_clr = 0; pc_ld = 0; pc_ic = 0; ir_ld = 0; i_data = 16'h0000;
        d_addr = 8'h00; d_wr = 0; rf_s = 0; rf_w_en = 0;
        rf_w_addr = 4'h0; rf_ra_addr = 4'h0; rf_rb_addr = 4'h0; alu_s = 3'd0;
    endtask

    // Build a constant in register r by doubling and incrementing.
    task automatic load_const(input int r, input logic [15:0] v);
        idle();
        rf_w_en = 1; rf_w_addr = 4'(r); alu_s = 3'd0;
        cyc();
        for (int i = 15; i >= 0; i--) begin
            alu_s = 3'd1; rf_ra_addr = 4'(r); rf_rb_addr = 4'(r);
            cyc();
            if (v[i]) begin
                alu_s = 3'd7;
                cyc();
            end
        end
        idle();
    endtask

    task automatic read_chk(input string tag, input int r, input logic [15:0] exp);
        idle();
        rf_ra_addr = 4'(r); alu_s = 3'd3;
        #1;
        check(tag, alu_out, exp);
        cyc();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        // Raw reset to bring the DUT out of an undefined start.
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        model_edge(16'h0000);
        idle();
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;

        // Clear data memory with r0 (zero) so every word is known.
        for (int i = 0; i < 256; i++) begin
            d_addr = 8'(i); d_wr = 1;
            cyc();
        end
        idle();
        cyc();

        // Reset scenario.
        load_const(3, 16'h1234);
        read_chk("pre_rst_r3", 3, 16'h1234);
        ir_ld = 1; i_data = 16'h0020;
        cyc();
        idle(); pc_ld = 1;
        cyc();
        idle();
        #1; check("pre_rst_pc", {8'h00, i_addr}, 16'h0020);
        rst = 1; pc_ic = 1; ir_ld = 1; i_data = 16'hFFFF; rf_w_en = 1; rf_w_addr = 4'd3; alu_s = 3'd7;
        cyc();
        idle(); alu_s = 3'd7;
        #1;
        check("rst_pc", {8'h00, i_addr}, 16'h0000);
        check("rst_ir", ir, 16'h0000);
        check("rst_alu_inc", alu_out, 16'h0001);
        cyc();
        read_chk("rst_r3", 3, 16'h0000);

        // PC scenarios.
        idle(); pc_ic = 1;
        repeat (3) cyc();
        idle(); #1; check("pc_inc3", {8'h00, i_addr}, 16'h0003);
        ir_ld = 1; i_data = 16'h00FF;
        cyc();
        idle(); pc_ld = 1;
        cyc();
        idle(); #1; check("pc_ff", {8'h00, i_addr}, 16'h00FF);
        pc_ic = 1;
        cyc();
        idle(); #1; check("pc_wrap", {8'h00, i_addr}, 16'h0000);
        ir_ld = 1; i_data = 16'h00AB;
        cyc();
        idle(); pc_ld = 1; ir_ld = 1; i_data = 16'h0055;
        cyc();
        idle(); #1; check("pc_ld_old_ir", {8'h00, i_addr}, 16'h00AB);
        pc_clr = 1; pc_ld = 1; pc_ic = 1;
        cyc();
        idle(); #1; check("pc_clr_prio", {8'h00, i_addr}, 16'h0000);

        // ADD / SUB.
        load_const(1, 16'hFFFF);
        load_const(2, 16'h0002);
        rf_ra_addr = 4'd1; rf_rb_addr = 4'd2; alu_s = 3'd1; rf_w_en = 1; rf_w_addr = 4'd4;
        cyc();
        alu_s = 3'd2; rf_w_addr = 4'd5;
        #1; check("sub_z0", {15'b0, alu_z}, 16'h0000);
        cyc();
        idle(); rf_ra_addr = 4'd1; rf_rb_addr = 4'd1; alu_s = 3'd2;
        #1; check("sub_z1", {15'b0, alu_z}, 16'h0001);
        cyc();
        read_chk("add_r4", 4, 16'h0001);
        read_chk("sub_r5", 5, 16'hFFFD);

        // STORE / LOAD.
        load_const(1, 16'hBEEF);
        rf_ra_addr = 4'd1; d_addr = 8'h10; d_wr = 1;
        cyc();
        idle(); d_addr = 8'h10;
        cyc();
        idle(); rf_s = 1; rf_w_en = 1; rf_w_addr = 4'd6;
        cyc();
        read_chk("load_r6", 6, 16'hBEEF);

        // Read-before-write.
        load_const(8, 16'h1111);
        load_const(9, 16'h2222);
        rf_ra_addr = 4'd8; d_addr = 8'h20; d_wr = 1;
        cyc();
        idle(); rf_ra_addr = 4'd9; d_addr = 8'h20; d_wr = 1;
        cyc();
        idle(); d_addr = 8'h20; rf_s = 1; rf_w_en = 1; rf_w_addr = 4'd10;
        cyc();
        idle(); rf_s = 1; rf_w_en = 1; rf_w_addr = 4'd11;
        cyc();
        read_chk("rbw_old", 10, 16'h1111);
        read_chk("rbw_new", 11, 16'h2222);

        // No write bypass.
        load_const(12, 16'h00FF);
        load_const(7, 16'h0042);
        rf_ra_addr = 4'd12; d_addr = 8'h30; d_wr = 1;
        cyc();
        idle(); d_addr = 8'h30;
        cyc();
        idle(); rf_s = 1; rf_w_en = 1; rf_w_addr = 4'd7; rf_ra_addr = 4'd7; alu_s = 3'd3;
        #1; check("nobypass_old", alu_out, 16'h0042);
        cyc();
        read_chk("nobypass_new", 7, 16'h00FF);

        // Randomized commands against the model.
        for (int n = 0; n < 1500; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            pc_clr     = ($urandom_range(0, 7) == 0);
            pc_ld      = ($urandom_range(0, 3) == 0);
            pc_ic      = 1'($urandom_range(0, 1));
            ir_ld      = 1'($urandom_range(0, 1));
            i_data     = 16'($urandom);
            d_addr     = 8'($urandom);
            d_wr       = ($urandom_range(0, 3) == 0);
            rf_s       = 1'($urandom_range(0, 1));
            rf_w_en    = 1'($urandom_range(0, 1));
            rf_w_addr  = 4'($urandom);
            rf_ra_addr = 4'($urandom);
            rf_rb_addr = 4'($urandom);
            alu_s      = 3'($urandom);
            cyc();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
